grng_sample_arbiter: RTL and testbench
======================================

// Module: grng_sample_arbiter
// PURPOSE
//  Shares the free-running 16-bit Gaussian sample stream (LFSR -> 4x hat_mul -> adder_block)
//  between NUM_REQ consumers. Holds off all consumers during pipeline warm-up after reset,
//  then grants round-robin bursts of BURST_LEN accepted samples. Sits directly after top.out.
//  Samples are i.i.d., so cycles with no taker are discarded.
// PARAMETERS
//  NUM_REQ        4   number of requesters, 2..8
//  BURST_LEN      4   accepted samples per grant, >=1
//  WARMUP_CYCLES  8   cycles after reset release before samples are valid, >=1
// PORTS
//  clk           in   1              rising-edge clock, single clock domain
//  reset         in   1              synchronous, active-high; same reset as the generator
//  grng_in       in   16             sample from generator, new value every cycle
//  req           in   NUM_REQ        level request per consumer
//  ready         in   NUM_REQ        consumer can take a sample delivered next cycle
//  sample_data   out  16             registered sample
//  sample_valid  out  NUM_REQ        one-hot destination of sample_data, 0 = none
//  gen_ready     out  1              warm-up complete
//  busy          out  1              burst in progress (state GRANT)
// BEHAVIOUR
//  - Reset (sync, high): state=WARMUP, warm_cnt=0, rr_ptr=0, burst_left=0, grant_idx=0;
//    sample_data=0, sample_valid=0, gen_ready=0, busy=0 in the cycle after reset is sampled.
//  - FSM WARMUP/IDLE/GRANT. All outputs registered.
//  - WARMUP: warm_cnt++ each cycle; at warm_cnt==WARMUP_CYCLES-1 -> IDLE. gen_ready=1 in IDLE/GRANT.
//  - IDLE: if |req, pick first set bit of req scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//    grant_idx<=winner, burst_left<=BURST_LEN, -> GRANT. req ignored in WARMUP.
//  - GRANT, per cycle, g=grant_idx, priority order:
//    a) req[g]==0: abort, sample_valid<=0, rr_ptr<=(g+1)%NUM_REQ, -> IDLE.
//    b) ready[g]==1: sample_data<=grng_in, sample_valid<=onehot(g), burst_left--;
//       if burst_left==1: rr_ptr<=(g+1)%NUM_REQ, -> IDLE.
//    c) ready[g]==0: sample_valid<=0, sample discarded, burst_left held (stall, no timeout).
//  - Latency grng_in -> sample_data: 1 cycle. sample_data holds last delivered value when
//    sample_valid==0.
//  - One mandatory IDLE bubble between bursts; max throughput BURST_LEN/(BURST_LEN+1).
//  - At most one sample_valid bit set; never set in WARMUP or IDLE output cycles.
//  - Requests from non-granted consumers wait; req changes on others never affect a burst.
//  - rr_ptr wraps NUM_REQ-1 -> 0. burst_left width $clog2(BURST_LEN+1).
//  - Reset mid-burst: burst dropped, no partial credit, full WARMUP repeated.
// STRUCTURE
//  - grng_pkg: SAMPLE_W=16, state enum {WARMUP, IDLE, GRANT}, onehot helper function.
//  - Sub-module rr_arbiter (NUM_REQ): combinational rotate-priority pick from req and rr_ptr,
//    outputs winner index + any_req. Rest (FSM, counters, output regs) in this module.
// TESTING  (defaults, grng_in driven as an incrementing counter for traceability)
//  1 reset 1 cycle, req=0 -> gen_ready=0 for 8 cycles after release then 1; sample_valid=0 always.
//  2 req=0001, ready=1111 after warm-up -> 4 consecutive sample_valid=0001, each sample_data =
//    grng_in of previous cycle; 1 bubble; next burst of 4.
//  3 req=1111, ready=1111 -> bursts granted to 0,1,2,3,0 in order, 4 samples each, 1 bubble between.
//  4 req=0010, ready[1] low 3 cycles after 2nd sample -> no valid for 3 cycles, then samples 3,4;
//    total exactly 4 for the burst.
//  5 req=0011, drop req[0] after 2 samples -> sample_valid=0 next, IDLE bubble, grant to 1.
//  6 reset during GRANT -> next cycle all outputs 0, rr_ptr=0; warm-up 8 cycles before any grant.

Source files
------------

// File: rtl/grng_pkg.sv
// Shared types and helpers for the Gaussian sample arbiter.
package grng_pkg;

  localparam int SAMPLE_W = 16;
  localparam int MAX_REQ  = 8;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_GRANT  = 2'd2
  } grng_state_e;

  // One-hot decode sized for the largest supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/grng_sample_arbiter_rr_arbiter.sv
// Combinational rotate-priority picker: first set req bit at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_req_o
);

  int unsigned k;

  always_comb begin
    winner_o  = '0;
    any_req_o = 1'b0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr_i) + i) % NUM_REQ;
      if (req_i[IDX_W'(k)] && !any_req_o) begin
        any_req_o = 1'b1;
        winner_o  = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/grng_sample_arbiter.sv
// Round-robin burst arbiter sharing one free-running Gaussian sample stream
// between NUM_REQ consumers, with a post-reset warm-up hold-off.
module grng_sample_arbiter
  import grng_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int BURST_LEN     = 4,
  parameter int WARMUP_CYCLES = 8,
  parameter int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] grng_in,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [NUM_REQ-1:0]  sample_valid,
  output logic                gen_ready,
  output logic                busy,
  output grng_state_e         dbg_state,
  output logic [IDX_W-1:0]    dbg_rr_ptr
);

  // Handshake: a consumer raising ready[g] in cycle N while granted receives
  // sample_data with sample_valid[g]=1 registered at the end of cycle N; there
  // is no back-pressure on the generator, so unaccepted samples are dropped.

  localparam int WC_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int BL_W = $clog2(BURST_LEN + 1);

  grng_state_e         state_q, state_d;
  logic [WC_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [BL_W-1:0]     burst_left_q, burst_left_d;
  logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
  logic [NUM_REQ-1:0]  sample_valid_q, sample_valid_d;
  logic                gen_ready_q, gen_ready_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    winner;
  logic                any_req;
  logic [IDX_W-1:0]    next_ptr;
  logic [MAX_REQ-1:0]  oh_full;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Pointer moves past the current holder whenever a burst ends, aborted or not.
  assign next_ptr = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
  assign oh_full  = onehot(3'(grant_idx_q));

  always_comb begin
    state_d        = state_q;
    warm_cnt_d     = warm_cnt_q;
    rr_ptr_d       = rr_ptr_q;
    grant_idx_d    = grant_idx_q;
    burst_left_d   = burst_left_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = '0;

    case (state_q)
      ST_WARMUP: begin
        if (warm_cnt_q == WC_W'(WARMUP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          warm_cnt_d = warm_cnt_q + WC_W'(1);
        end
      end

      ST_IDLE: begin
        if (any_req) begin
          grant_idx_d  = winner;
          burst_left_d = BL_W'(BURST_LEN);
          state_d      = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!req[grant_idx_q]) begin
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else if (ready[grant_idx_q]) begin
          sample_data_d  = grng_in;
          sample_valid_d = NUM_REQ'(oh_full);
          burst_left_d   = burst_left_q - BL_W'(1);
          if (burst_left_q == BL_W'(1)) begin
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_WARMUP;
      end
    endcase

    gen_ready_d = (state_d != ST_WARMUP);
    busy_d      = (state_d == ST_GRANT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_WARMUP;
      warm_cnt_q     <= '0;
      rr_ptr_q       <= '0;
      grant_idx_q    <= '0;
      burst_left_q   <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= '0;
      gen_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      warm_cnt_q     <= warm_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_idx_q    <= grant_idx_d;
      burst_left_q   <= burst_left_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      gen_ready_q    <= gen_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign gen_ready    = gen_ready_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;
  assign dbg_rr_ptr   = rr_ptr_q;

endmodule

// File: tb/tb_grng_sample_arbiter.sv
// Directed bench for grng_sample_arbiter with default parameters and a counting sample stream.
module tb_grng_sample_arbiter;
  import grng_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   grng_in = 16'h1000;
  logic [3:0]    req = 4'b0000;
  logic [3:0]    ready = 4'b0000;
  logic [15:0]   sample_data;
  logic [3:0]    sample_valid;
  logic          gen_ready;
  logic          busy;
  grng_state_e   dbg_state;
  logic [1:0]    dbg_rr_ptr;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   applied;
  logic [15:0]   held;

  grng_sample_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .grng_in      (grng_in),
    .req          (req),
    .ready        (ready),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .gen_ready    (gen_ready),
    .busy         (busy),
    .dbg_state    (dbg_state),
    .dbg_rr_ptr   (dbg_rr_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks: applied is the grng_in value seen by the edge just taken
  task automatic step();
    applied = grng_in;
    @(posedge clk);
    #1;
    grng_in = grng_in + 16'd1;
  endtask

  task automatic do_reset_and_warm();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    req = 4'b0000;
    ready = 4'b0000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (sample_valid !== 4'b0 || gen_ready !== 1'b0 || busy !== 1'b0 || sample_data !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b gr=%b busy=%b data=%h required 0/0/0/0000",
               sample_valid, gen_ready, busy, sample_data);
    end
    n_cmp++;
    if (dbg_state !== ST_WARMUP || dbg_rr_ptr !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: got state=%0d ptr=%0d required 0/0", dbg_state, dbg_rr_ptr);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      n_cmp++;
      if (gen_ready !== 1'b0 || sample_valid !== 4'b0) begin
        n_bad++;
        $display("FAIL warmup_%0d: got gr=%b v=%b required 0/0000", i, gen_ready, sample_valid);
      end
    end
    step();
    n_cmp++;
    if (gen_ready !== 1'b1 || sample_valid !== 4'b0 || dbg_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL warmup_done: got gr=%b v=%b state=%0d required 1/0000/1",
               gen_ready, sample_valid, dbg_state);
    end
    req = 4'b1111;
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL warmup_grant: got busy=%b required 1", busy);
    end
  endtask

  task automatic test_single_stream();
    do_reset_and_warm();
    req = 4'b0001;
    ready = 4'b1111;
    step();
    n_cmp++;
    if (sample_valid !== 4'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_grant: got v=%b busy=%b required 0000/1", sample_valid, busy);
    end
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++) begin
        step();
        n_cmp++;
        if (sample_valid !== 4'b0001 || sample_data !== applied) begin
          n_bad++;
          $display("FAIL stream_b%0d_s%0d: got v=%b d=%h required 0001/%h",
                   b, s, sample_valid, sample_data, applied);
        end
      end
      if (b == 0) begin
        step();
        n_cmp++;
        if (sample_valid !== 4'b0) begin
          n_bad++;
          $display("FAIL stream_bubble: got v=%b required 0000", sample_valid);
        end
      end
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if (sample_valid !== 4'b0 || busy !== 1'b0 || dbg_rr_ptr !== 2'd1) begin
      n_bad++;
      $display("FAIL stream_end: got v=%b busy=%b ptr=%0d required 0000/0/1",
               sample_valid, busy, dbg_rr_ptr);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v;
    do_reset_and_warm();
    req = 4'b1111;
    ready = 4'b1111;
    step();
    for (int b = 0; b < 5; b++) begin
      exp_v = 4'(1 << (b % 4));
      for (int s = 0; s < 4; s++) begin
        step();
        n_cmp++;
        if (sample_valid !== exp_v || sample_data !== applied) begin
          n_bad++;
          $display("FAIL rr_b%0d_s%0d: got v=%b d=%h required %b/%h",
                   b, s, sample_valid, sample_data, exp_v, applied);
        end
      end
      if (b < 4) begin
        step();
        n_cmp++;
        if (sample_valid !== 4'b0) begin
          n_bad++;
          $display("FAIL rr_bubble_%0d: got v=%b required 0000", b, sample_valid);
        end
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_stall();
    do_reset_and_warm();
    req = 4'b0010;
    ready = 4'b1111;
    step();
    for (int s = 0; s < 2; s++) begin
      step();
      n_cmp++;
      if (sample_valid !== 4'b0010 || sample_data !== applied) begin
        n_bad++;
        $display("FAIL stall_pre_%0d: got v=%b d=%h required 0010/%h",
                 s, sample_valid, sample_data, applied);
      end
    end
    held = applied;
    ready = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      step();
      n_cmp++;
      if (sample_valid !== 4'b0 || sample_data !== held || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_wait_%0d: got v=%b d=%h busy=%b required 0000/%h/1",
                 s, sample_valid, sample_data, busy, held);
      end
    end
    ready = 4'b1111;
    for (int s = 0; s < 2; s++) begin
      step();
      n_cmp++;
      if (sample_valid !== 4'b0010 || sample_data !== applied) begin
        n_bad++;
        $display("FAIL stall_post_%0d: got v=%b d=%h required 0010/%h",
                 s, sample_valid, sample_data, applied);
      end
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if (sample_valid !== 4'b0 || busy !== 1'b0 || dbg_rr_ptr !== 2'd2) begin
      n_bad++;
      $display("FAIL stall_total: got v=%b busy=%b ptr=%0d required 0000/0/2",
               sample_valid, busy, dbg_rr_ptr);
    end
  endtask

  task automatic test_abort();
    do_reset_and_warm();
    req = 4'b0011;
    ready = 4'b1111;
    step();
    for (int s = 0; s < 2; s++) begin
      step();
      n_cmp++;
      if (sample_valid !== 4'b0001) begin
        n_bad++;
        $display("FAIL abort_pre_%0d: got v=%b required 0001", s, sample_valid);
      end
    end
    req = 4'b0010;
    step();
    n_cmp++;
    if (sample_valid !== 4'b0 || busy !== 1'b0 || dbg_rr_ptr !== 2'd1) begin
      n_bad++;
      $display("FAIL abort_drop: got v=%b busy=%b ptr=%0d required 0000/0/1",
               sample_valid, busy, dbg_rr_ptr);
    end
    step();
    n_cmp++;
    if (sample_valid !== 4'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_regrant: got v=%b busy=%b required 0000/1", sample_valid, busy);
    end
    for (int s = 0; s < 4; s++) begin
      step();
      n_cmp++;
      if (sample_valid !== 4'b0010 || sample_data !== applied) begin
        n_bad++;
        $display("FAIL abort_next_%0d: got v=%b d=%h required 0010/%h",
                 s, sample_valid, sample_data, applied);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset_and_warm();
    req = 4'b0001;
    ready = 4'b1111;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (sample_valid !== 4'b0 || gen_ready !== 1'b0 || busy !== 1'b0 || sample_data !== 16'h0 ||
        dbg_rr_ptr !== 2'd0 || dbg_state !== ST_WARMUP) begin
      n_bad++;
      $display("FAIL midrst_outputs: got v=%b gr=%b busy=%b d=%h ptr=%0d st=%0d required all 0",
               sample_valid, gen_ready, busy, sample_data, dbg_rr_ptr, dbg_state);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      n_cmp++;
      if (gen_ready !== 1'b0 || sample_valid !== 4'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_warm_%0d: got gr=%b v=%b busy=%b required 0/0000/0",
                 i, gen_ready, sample_valid, busy);
      end
    end
    step();
    n_cmp++;
    if (gen_ready !== 1'b1 || busy !== 1'b0 || sample_valid !== 4'b0) begin
      n_bad++;
      $display("FAIL midrst_idle: got gr=%b busy=%b v=%b required 1/0/0000",
               gen_ready, busy, sample_valid);
    end
    step();
    for (int s = 0; s < 4; s++) begin
      step();
      n_cmp++;
      if (sample_valid !== 4'b0001 || sample_data !== applied) begin
        n_bad++;
        $display("FAIL midrst_burst_%0d: got v=%b d=%h required 0001/%h",
                 s, sample_valid, sample_data, applied);
      end
    end
    step();
    n_cmp++;
    if (sample_valid !== 4'b0) begin
      n_bad++;
      $display("FAIL midrst_bubble: got v=%b required 0000", sample_valid);
    end
    req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_stall();
    test_abort();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
